cycle_sequencer: RTL and testbench

CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

---
 rtl/mips_pkg.sv | 36 +++
 rtl/next_pc_calc.sv | 21 ++
 rtl/cycle_sequencer.sv | 148 ++++++++++++++
 tb/tb_cycle_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encoding, opcodes, writable register window.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package mips_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // Only t0-t7 and s0-s7 may be written back.
  localparam logic [4:0] REG_LO = 5'd8;
  localparam logic [4:0] REG_HI = 5'd23;

  function automatic logic op_known(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
           (op == OP_SW)    || (op == OP_BEQ)  || (op == OP_HALT);
  endfunction

  function automatic logic reg_writable(input logic [4:0] r);
    return (r >= REG_LO) && (r <= REG_HI);
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next program counter: pc+4, or pc+4 plus the word-scaled signed branch offset.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is committed.
module next_pc_calc (
  input  logic [31:0] pc_i,
  input  logic [15:0] imm_i,
  input  logic        take_branch_i,
  output logic [31:0] next_pc_o
);

  logic [31:0] pc_plus4;
  logic [31:0] offset;

  // Sign-extended, word-aligned offset; all sums wrap modulo 2^32.
  always_comb begin
    pc_plus4  = pc_i + 32'd4;
    offset    = {{14{imm_i[15]}}, imm_i, 2'b00};
    next_pc_o = take_branch_i ? (pc_plus4 + offset) : pc_plus4;
  end

endmodule

// File: rtl/cycle_sequencer.sv
// Multi-cycle instruction sequencer: IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT control with PC and retire count.
// Latency: 4 cycles for ALU ops, 3 for beq, 4+ (lw 5+) for memory ops, plus fetch/memory wait time.
// Backpressure: FETCH stalls until instr_valid, MEM stalls until mem_ready; both waits are unbounded.
module cycle_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic [31:0] ir,
  input  logic        zero_flag,
  output logic        dmem_rd,
  output logic        dmem_wr,
  input  logic        mem_ready,
  output logic        reg_we,
  output logic [4:0]  reg_waddr,
  output logic        mem_to_reg,
  output logic [31:0] pc,
  output logic [2:0]  state,
  output logic        halted,
  output logic        err,
  output logic [31:0] retired
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] retired_q, retired_d;
  logic        err_q, err_d;

  logic [5:0]  opcode;
  logic        retire;
  logic        take_branch;
  logic [31:0] next_pc;

  assign opcode = ir_q[31:26];

  // An instruction completes on every hand-back to FETCH from EXEC, MEM or WB.
  assign retire = ((state_q == ST_EXEC) && (opcode == OP_BEQ)) ||
                  ((state_q == ST_MEM) && (opcode == OP_SW) && mem_ready) ||
                  (state_q == ST_WB);

  assign take_branch = (state_q == ST_EXEC) && (opcode == OP_BEQ) && zero_flag;

  next_pc_calc u_next_pc (
    .pc_i          (pc_q),
    .imm_i         (ir_q[15:0]),
    .take_branch_i (take_branch),
    .next_pc_o     (next_pc)
  );

  // State register; reset abandons any pending fetch or memory wait.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH:  if (instr_valid) state_d = ST_DECODE;
      ST_DECODE: begin
        if ((opcode == OP_HALT) || !op_known(opcode)) state_d = ST_HALT;
        else                                         state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (opcode)
          OP_RTYPE, OP_ADDI: state_d = ST_WB;
          OP_LW, OP_SW:      state_d = ST_MEM;
          OP_BEQ:            state_d = ST_FETCH;
          default:           state_d = ST_HALT;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) state_d = (opcode == OP_LW) ? ST_WB : ST_FETCH;
      end
      ST_WB:     state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath register next values: ir capture, PC advance, retire count, error latch.
  always_comb begin
    ir_d      = ir_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    err_d     = err_q;
    if ((state_q == ST_FETCH) && instr_valid) ir_d = instr;
    if (retire) begin
      pc_d      = next_pc;
      retired_d = retired_q + 32'd1;
    end
    if ((state_q == ST_DECODE) && !op_known(opcode)) err_d = 1'b1;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      ir_q      <= 32'd0;
      retired_q <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      err_q     <= err_d;
    end
  end

  // Outputs decoded from the current state only, so requests are exclusive by construction.
  always_comb begin
    imem_req   = 1'b0;
    dmem_rd    = 1'b0;
    dmem_wr    = 1'b0;
    reg_we     = 1'b0;
    reg_waddr  = (opcode == OP_RTYPE) ? ir_q[15:11] : ir_q[20:16];
    mem_to_reg = (opcode == OP_LW);
    halted     = (state_q == ST_HALT);
    case (state_q)
      ST_FETCH: imem_req = 1'b1;
      ST_MEM: begin
        dmem_rd = (opcode == OP_LW);
        dmem_wr = (opcode == OP_SW);
      end
      ST_WB:    reg_we = reg_writable(reg_waddr);
      default:  ;
    endcase
  end

  assign state   = state_q;
  assign pc      = pc_q;
  assign ir      = ir_q;
  assign retired = retired_q;
  assign err     = err_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer: reset, ALU/memory/branch flows, register window, halt, mid-wait reset.
// Latency: stimulus driven 1ns after each rising edge, outputs sampled at the same point.
// Backpressure: instr_valid and mem_ready are driven by the bench with explicit delays.
module tb_cycle_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        zero_flag = 1'b0;
  logic        mem_ready = 1'b0;

  logic        imem_req, dmem_rd, dmem_wr, reg_we, mem_to_reg, halted, err;
  logic [31:0] ir, pc, retired;
  logic [4:0]  reg_waddr;
  logic [2:0]  state;

  logic        imem_req_w, dmem_rd_w, dmem_wr_w, reg_we_w, mem_to_reg_w, halted_w, err_w;
  logic [31:0] ir_w, pc_w, retired_w;
  logic [4:0]  reg_waddr_w;
  logic [2:0]  state_w;

  int tests_run = 0;
  int tests_failed = 0;

  int          we_cnt, rd_cnt, wr_cnt;
  int          excl_bad = 0;
  logic [4:0]  we_addr;
  logic        we_m2r;

  always #5 clk = ~clk;

  cycle_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_req(imem_req),
    .instr_valid(instr_valid), .instr(instr), .ir(ir), .zero_flag(zero_flag),
    .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .mem_ready(mem_ready), .reg_we(reg_we),
    .reg_waddr(reg_waddr), .mem_to_reg(mem_to_reg), .pc(pc), .state(state),
    .halted(halted), .err(err), .retired(retired)
  );

  cycle_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_req(imem_req_w),
    .instr_valid(instr_valid), .instr(instr), .ir(ir_w), .zero_flag(zero_flag),
    .dmem_rd(dmem_rd_w), .dmem_wr(dmem_wr_w), .mem_ready(mem_ready), .reg_we(reg_we_w),
    .reg_waddr(reg_waddr_w), .mem_to_reg(mem_to_reg_w), .pc(pc_w), .state(state_w),
    .halted(halted_w), .err(err_w), .retired(retired_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From FETCH: present one instruction, then run until back in FETCH or HALT,
  // recording what the write-back and memory strobes did along the way.
  task automatic run_instr(input logic [31:0] w, input logic zf, input int mem_wait);
    int mem_cyc;
    bit done;
    mem_cyc = 0;
    done    = 1'b0;
    we_cnt  = 0;
    rd_cnt  = 0;
    wr_cnt  = 0;
    we_addr = 5'd0;
    we_m2r  = 1'b0;
    instr = w;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    zero_flag = zf;
    for (int i = 0; i < 40 && !done; i++) begin
      if (reg_we) begin
        we_cnt++;
        we_addr = reg_waddr;
        we_m2r  = mem_to_reg;
      end
      if (dmem_rd) rd_cnt++;
      if (dmem_wr) wr_cnt++;
      if ($countones({imem_req, dmem_rd, dmem_wr, reg_we}) > 1) excl_bad++;
      if (state == 3'd1 || state == 3'd6) begin
        done = 1'b1;
      end else begin
        mem_ready = (state == 3'd4) && (mem_cyc == mem_wait);
        if (state == 3'd4) mem_cyc++;
        step();
      end
    end
    mem_ready = 1'b0;
    zero_flag = 1'b0;
    check("run_completes", {31'd0, done}, 32'd1);
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_pc_wrapdut", pc_w, 32'hFFFF_FFFC);
    check("rst_ir", ir, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_flags", {30'd0, halted, err}, 32'd0);
    check("rst_strobes", {28'd0, imem_req, dmem_rd, dmem_wr, reg_we}, 32'd0);

    // Stray handshakes in IDLE are ignored
    rst_n = 1'b1;
    instr = 32'h02328020;
    instr_valid = 1'b1;
    mem_ready = 1'b1;
    step();
    check("idle_ignores_valid", {29'd0, state}, 32'd0);
    check("idle_ir_kept", ir, 32'd0);
    instr_valid = 1'b0;

    // add $s0,$s1,$s2 with explicit state walk
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_fetch", {29'd0, state}, 32'd1);
    check("fetch_imem_req", {31'd0, imem_req}, 32'd1);
    step();
    check("fetch_wait_ignores_ready", {29'd0, state}, 32'd1);
    mem_ready = 1'b0;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    check("decode_state", {29'd0, state}, 32'd2);
    check("ir_loaded", ir, 32'h02328020);
    check("decode_no_req", {31'd0, imem_req}, 32'd0);
    step();
    check("exec_state", {29'd0, state}, 32'd3);
    step();
    check("wb_state", {29'd0, state}, 32'd5);
    check("wb_reg_we", {31'd0, reg_we}, 32'd1);
    check("wb_waddr", {27'd0, reg_waddr}, 32'd16);
    check("wb_m2r", {31'd0, mem_to_reg}, 32'd0);
    step();
    check("add_back_fetch", {29'd0, state}, 32'd1);
    check("add_we_dropped", {31'd0, reg_we}, 32'd0);
    check("add_pc", pc, 32'd4);
    check("add_retired", retired, 32'd1);
    check("add_pc_wrap", pc_w, 32'd0);
    check("add_retired_wrapdut", retired_w, 32'd1);

    // lw $t0,8($s1) with 3-cycle memory delay
    run_instr(32'h8E280008, 1'b0, 3);
    check("lw_rd_cycles", rd_cnt, 32'd4);
    check("lw_wr_cycles", wr_cnt, 32'd0);
    check("lw_we_cycles", we_cnt, 32'd1);
    check("lw_waddr", {27'd0, we_addr}, 32'd8);
    check("lw_m2r", {31'd0, we_m2r}, 32'd1);
    check("lw_pc", pc, 32'd8);
    check("lw_retired", retired, 32'd2);

    // sw $t0,8($s1) with 1-cycle memory delay
    run_instr(32'hAE280008, 1'b0, 1);
    check("sw_wr_cycles", wr_cnt, 32'd2);
    check("sw_no_we", we_cnt, 32'd0);
    check("sw_pc", pc, 32'h0C);
    check("sw_retired", retired, 32'd3);

    // R-type writing $2: suppressed write, still retires
    run_instr(32'h02321020, 1'b0, 0);
    check("r2_no_we", we_cnt, 32'd0);
    check("r2_pc", pc, 32'h10);
    check("r2_retired", retired, 32'd4);

    // beq at 0x10 with offset -1 word, taken then not taken
    run_instr(32'h1000FFFF, 1'b1, 0);
    check("beq_taken_pc", pc, 32'h10);
    check("beq_taken_no_we", we_cnt, 32'd0);
    check("beq_taken_retired", retired, 32'd5);
    run_instr(32'h1000FFFF, 1'b0, 0);
    check("beq_nt_pc", pc, 32'h14);
    check("beq_nt_no_we", we_cnt, 32'd0);
    check("beq_nt_retired", retired, 32'd6);

    // addi $s0,$zero,5 targets rt
    run_instr(32'h20100005, 1'b0, 0);
    check("addi_we", we_cnt, 32'd1);
    check("addi_waddr", {27'd0, we_addr}, 32'd16);
    check("addi_m2r", {31'd0, we_m2r}, 32'd0);
    check("addi_pc", pc, 32'h18);

    // Clean halt, then start pulses must not wake it
    run_instr(32'hFC000000, 1'b0, 0);
    check("halt_state", {29'd0, state}, 32'd6);
    check("halt_flags", {30'd0, halted, err}, 32'b10);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      step();
      start = 1'b0;
      step();
    end
    check("halt_absorbing", {29'd0, state}, 32'd6);
    check("halt_no_req", {31'd0, imem_req}, 32'd0);
    check("halt_pc_kept", pc, 32'h18);
    check("halt_retired_kept", retired, 32'd7);

    // Illegal opcode halts with err
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst2_clears_halt", {29'd0, state, halted}, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    run_instr(32'h7C000000, 1'b0, 0);
    check("illegal_state", {29'd0, state}, 32'd6);
    check("illegal_flags", {30'd0, halted, err}, 32'b11);
    check("illegal_no_retire", retired, 32'd0);

    // Reset during a pending lw memory wait
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst3_err_clear", {31'd0, err}, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    run_instr(32'h02328020, 1'b0, 0);
    check("pre_abort_retired", retired, 32'd1);
    instr = 32'h8E280008;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    step();
    check("abort_in_mem", {31'd0, dmem_rd}, 32'd1);
    step();
    rst_n = 1'b0;
    step();
    check("abort_state", {29'd0, state}, 32'd0);
    check("abort_dmem_rd", {31'd0, dmem_rd}, 32'd0);
    check("abort_reg_we", {31'd0, reg_we}, 32'd0);
    check("abort_pc", pc, 32'd0);
    check("abort_pc_wrapdut", pc_w, 32'hFFFF_FFFC);
    check("abort_retired", retired, 32'd0);
    rst_n = 1'b1;

    check("strobes_exclusive", excl_bad, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
